// File: rtl/mux_pkg.sv
// Shared definitions for the sequential slice multiplexer: FSM state
// encoding and the slice-index width helper.
package mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Width of an index able to address n slices; never narrower than one bit
  // so a single-slice operand still has a legal index port.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_n.sv
// Combinational N:1 slice selector, the generalised form of the 2:1 nibble
// mux. Indices beyond NUM_SLICES-1 select all-zero.
module mux_n
  import mux_pkg::*;
#(
  parameter  int SLICE_W    = 4,
  parameter  int NUM_SLICES = 2,
  localparam int IDX_W      = idx_width(NUM_SLICES)
) (
  input  logic [SLICE_W*NUM_SLICES-1:0] data,
  input  logic [IDX_W-1:0]              idx,
  output logic [SLICE_W-1:0]            y
);

  // Select the slice whose physical position matches idx.
  always_comb begin
    // NOTE: default assignment first so no path leaves y unassigned (no latch).
    y = '0;
    for (int k = 0; k < NUM_SLICES; k++) begin
      if (idx == IDX_W'(k)) y = data[k*SLICE_W +: SLICE_W];
    end
  end

endmodule

// File: rtl/slice_seq_mux.sv
// Captures a wide operand on start and presents it one slice per accepted
// transfer (LSB- or MSB-first) to the partial-product multiplier, using a
// valid/ready handshake. Every output is decoded from registered state only.
module slice_seq_mux
  import mux_pkg::*;
#(
  parameter  int SLICE_W    = 4,
  parameter  int NUM_SLICES = 2,
  localparam int IDX_W      = idx_width(NUM_SLICES)
) (
  input  logic                          clk,
  input  logic                          reset_a,
  input  logic                          start,
  input  logic                          msb_first,
  input  logic [SLICE_W*NUM_SLICES-1:0] data_in,
  input  logic                          out_ready,
  output logic [SLICE_W-1:0]            slice_out,
  output logic [IDX_W-1:0]              slice_idx,
  output logic                          slice_valid,
  output logic                          last,
  output logic                          busy,
  output logic                          done
);

  localparam int              OP_W     = SLICE_W * NUM_SLICES;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  state_t            state;
  logic [OP_W-1:0]   operand;
  logic [IDX_W-1:0]  count;
  logic              dir;

  // Sequencer: capture in IDLE, step through slices on each transfer in RUN,
  // spend one cycle in DONE to pulse done.
  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      state   <= ST_IDLE;
      operand <= '0;
      count   <= '0;
      dir     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from
      // pre-edge values, independent of statement order.
      case (state)
        ST_IDLE: begin
          if (start) begin
            operand <= data_in;
            dir     <= msb_first;
            count   <= '0;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          // slice_valid is high throughout RUN, so out_ready alone marks a transfer.
          if (out_ready) begin
            if (count == LAST_IDX) state <= ST_DONE;
            else                   count <= count + IDX_W'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Status decodes straight from the state register.
  assign slice_valid = (state == ST_RUN);
  assign busy        = (state != ST_IDLE);
  assign done        = (state == ST_DONE);
  assign last        = slice_valid & (count == LAST_IDX);

  // count is the transfer ordinal; dir mirrors it to give the physical index.
  assign slice_idx   = dir ? (LAST_IDX - count) : count;

  mux_n #(
    .SLICE_W    (SLICE_W),
    .NUM_SLICES (NUM_SLICES)
  ) u_mux (
    .data (operand),
    .idx  (slice_idx),
    .y    (slice_out)
  );

endmodule

// File: tb/tb_slice_seq_mux.sv
// Directed bench for slice_seq_mux: three instances (2, 4 and 1 slices)
// share clock and reset; expected values are hand-computed constants.
module tb_slice_seq_mux;

  logic clk = 1'b0;
  logic reset_a;

  always #5 clk = ~clk;

  // Instance A: SLICE_W=4, NUM_SLICES=2
  logic       start_a, msb_a, ready_a;
  logic [7:0] data_a;
  logic [3:0] out_a;
  logic [0:0] idx_a;
  logic       valid_a, last_a, busy_a, done_a;

  // Instance B: SLICE_W=4, NUM_SLICES=4
  logic        start_b, msb_b, ready_b;
  logic [15:0] data_b;
  logic [3:0]  out_b;
  logic [1:0]  idx_b;
  logic        valid_b, last_b, busy_b, done_b;

  // Instance C: SLICE_W=4, NUM_SLICES=1
  logic       start_c, msb_c, ready_c;
  logic [3:0] data_c;
  logic [3:0] out_c;
  logic [0:0] idx_c;
  logic       valid_c, last_c, busy_c, done_c;

  slice_seq_mux #(.SLICE_W(4), .NUM_SLICES(2)) dut_a (
    .clk(clk), .reset_a(reset_a), .start(start_a), .msb_first(msb_a),
    .data_in(data_a), .out_ready(ready_a), .slice_out(out_a), .slice_idx(idx_a),
    .slice_valid(valid_a), .last(last_a), .busy(busy_a), .done(done_a)
  );

  slice_seq_mux #(.SLICE_W(4), .NUM_SLICES(4)) dut_b (
    .clk(clk), .reset_a(reset_a), .start(start_b), .msb_first(msb_b),
    .data_in(data_b), .out_ready(ready_b), .slice_out(out_b), .slice_idx(idx_b),
    .slice_valid(valid_b), .last(last_b), .busy(busy_b), .done(done_b)
  );

  slice_seq_mux #(.SLICE_W(4), .NUM_SLICES(1)) dut_c (
    .clk(clk), .reset_a(reset_a), .start(start_c), .msb_first(msb_c),
    .data_in(data_c), .out_ready(ready_c), .slice_out(out_c), .slice_idx(idx_c),
    .slice_valid(valid_c), .last(last_c), .busy(busy_c), .done(done_c)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic ctl_a(input string tag, input logic v, input logic l, input logic b, input logic d);
    check({tag, "_valid"}, 32'(valid_a), 32'(v));
    check({tag, "_last"},  32'(last_a),  32'(l));
    check({tag, "_busy"},  32'(busy_a),  32'(b));
    check({tag, "_done"},  32'(done_a),  32'(d));
  endtask

  task automatic dat_a(input string tag, input logic [3:0] o, input logic [0:0] i);
    check({tag, "_slice"}, 32'(out_a), 32'(o));
    check({tag, "_idx"},   32'(idx_a), 32'(i));
  endtask

  // Watchdog: a hung handshake must still end the run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int xfer;
    int done_cnt;
    logic finished;

    reset_a = 1'b0;
    start_a = 0; msb_a = 0; ready_a = 0; data_a = '0;
    start_b = 0; msb_b = 0; ready_b = 0; data_b = '0;
    start_c = 0; msb_c = 0; ready_c = 0; data_c = '0;
    repeat (2) tick();

    // Reset state
    ctl_a("rst", 0, 0, 0, 0);
    dat_a("rst", 4'h0, 1'b0);
    check("rst_b_busy",  32'(busy_b),  32'd0);
    check("rst_c_valid", 32'(valid_c), 32'd0);
    reset_a = 1'b1;
    tick();

    // 1: LSB-first, out_ready tied high
    start_a = 1; data_a = 8'hA6; msb_a = 0; ready_a = 1;
    tick(); start_a = 0;
    ctl_a("t1_s0", 1, 0, 1, 0); dat_a("t1_s0", 4'h6, 1'b0);
    tick();
    ctl_a("t1_s1", 1, 1, 1, 0); dat_a("t1_s1", 4'hA, 1'b1);
    tick();
    ctl_a("t1_done", 0, 0, 1, 1);
    tick();
    ctl_a("t1_idle", 0, 0, 0, 0);

    // 2: MSB-first
    start_a = 1; data_a = 8'hA6; msb_a = 1;
    tick(); start_a = 0; msb_a = 0;
    ctl_a("t2_s0", 1, 0, 1, 0); dat_a("t2_s0", 4'hA, 1'b1);
    tick();
    ctl_a("t2_s1", 1, 1, 1, 0); dat_a("t2_s1", 4'h6, 1'b0);
    tick();
    ctl_a("t2_done", 0, 0, 1, 1);
    tick();
    ctl_a("t2_idle", 0, 0, 0, 0);

    // 3: backpressure on the first slice
    start_a = 1; data_a = 8'hA6; ready_a = 0;
    tick(); start_a = 0;
    for (int i = 0; i < 3; i++) begin
      ctl_a($sformatf("t3_hold%0d", i), 1, 0, 1, 0);
      dat_a($sformatf("t3_hold%0d", i), 4'h6, 1'b0);
      tick();
    end
    ctl_a("t3_hold3", 1, 0, 1, 0); dat_a("t3_hold3", 4'h6, 1'b0);
    ready_a = 1;
    tick();
    ctl_a("t3_s1", 1, 1, 1, 0); dat_a("t3_s1", 4'hA, 1'b1);
    tick();
    ctl_a("t3_done", 0, 0, 1, 1);
    tick();
    ctl_a("t3_idle", 0, 0, 0, 0);

    // 4: start held and data changed while busy: no restart, no recapture
    start_a = 1; data_a = 8'hA6;
    tick(); data_a = 8'hFF; msb_a = 1;
    dat_a("t4_s0", 4'h6, 1'b0);
    tick();
    ctl_a("t4_s1", 1, 1, 1, 0); dat_a("t4_s1", 4'hA, 1'b1);
    tick();
    ctl_a("t4_done", 0, 0, 1, 1);
    start_a = 0; msb_a = 0;
    tick();
    ctl_a("t4_idle", 0, 0, 0, 0);

    // 5: asynchronous reset during the second slice, then a clean sequence
    start_a = 1; data_a = 8'hA6;
    tick(); start_a = 0;
    tick();
    ctl_a("t5_pre", 1, 1, 1, 0);
    #2 reset_a = 1'b0;
    #1;
    ctl_a("t5_rst", 0, 0, 0, 0);
    dat_a("t5_rst", 4'h0, 1'b0);
    tick();
    ctl_a("t5_rst_hold", 0, 0, 0, 0);
    reset_a = 1'b1;
    tick();
    start_a = 1; data_a = 8'h3C;
    tick(); start_a = 0;
    ctl_a("t5_s0", 1, 0, 1, 0); dat_a("t5_s0", 4'hC, 1'b0);
    tick();
    ctl_a("t5_s1", 1, 1, 1, 0); dat_a("t5_s1", 4'h3, 1'b1);
    tick();
    ctl_a("t5_done", 0, 0, 1, 1);
    tick();
    ctl_a("t5_idle", 0, 0, 0, 0);

    // 6a: four slices, random out_ready
    start_b = 1; data_b = 16'h1234; msb_b = 0;
    tick(); start_b = 0; data_b = 16'hFFFF;
    xfer = 0; done_cnt = 0; finished = 1'b0;
    for (int cyc = 0; cyc < 100 && !finished; cyc++) begin
      if (done_b) done_cnt++;
      if (done_cnt > 0 && !busy_b) finished = 1'b1;
      ready_b = (cyc < 40) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (valid_b && ready_b) begin
        check($sformatf("t6_x%0d_slice", xfer), 32'(out_b),  32'(4 - xfer));
        check($sformatf("t6_x%0d_idx", xfer),   32'(idx_b),  32'(xfer));
        check($sformatf("t6_x%0d_last", xfer),  32'(last_b), 32'(xfer == 3));
        xfer++;
      end
      if (!finished) tick();
    end
    check("t6_finished",  32'(finished), 32'd1);
    check("t6_transfers", 32'(xfer),     32'd4);
    check("t6_done_cnt",  32'(done_cnt), 32'd1);
    ready_b = 0;

    // 6b: single-slice operand
    start_c = 1; data_c = 4'h9; msb_c = 1; ready_c = 1;
    tick(); start_c = 0;
    check("t7_valid", 32'(valid_c), 32'd1);
    check("t7_slice", 32'(out_c),   32'h9);
    check("t7_idx",   32'(idx_c),   32'd0);
    check("t7_last",  32'(last_c),  32'd1);
    tick();
    check("t7_done",  32'(done_c),  32'd1);
    check("t7_dvld",  32'(valid_c), 32'd0);
    tick();
    check("t7_idle",  32'(busy_c),  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
